regfile_write_arbiter: RTL

// - Shares the single regfile write port between NUM_REQ writeback sources
//   (req 0 = pipeline writeback, req 1 = load/multicycle unit, req 2 = debug/init).
// - Fixed priority with a starvation guard; one write per cycle, registered to the regfile.
// - Keeps a pending-write scoreboard (busy_o) for hazard/stall logic in the core.
// - Sits between the writeback sources and regfile write_enable_i/write_addr_i/write_data_i.

---
 rtl/regfile_pkg.sv | 30 +++
 rtl/regfile_write_arbiter_if.sv | 51 +++++
 rtl/prio_arbiter.sv | 35 +++
 rtl/regfile_write_arbiter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the register-file write path.
//   REG_ADDR_W / REG_DATA_W : default address / data widths of the regfile
//   NUM_GPR                 : number of real registers (R0..R14)
//   R15_ADDR                : address that decodes to no register; writes are dropped
//   wb_req_t                : one writeback request (destination + data)
//   wait_cnt_w()            : width needed to count 0..max inclusive
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int REG_DATA_W = 32;
    localparam int NUM_GPR    = 15;

    localparam logic [REG_ADDR_W-1:0] R15_ADDR = 4'hF;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

    // Width of a saturating counter that must be able to hold the value max.
    function automatic int wait_cnt_w(input int max);
        int w;
        w = $clog2(max + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : regfile_pkg

// File: rtl/regfile_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter_if
// Bundles everything that crosses the arbiter boundary except clock and reset:
//   requester side : req_valid_i, req_addr_i, req_data_i (packed per source),
//                    req_ready_o (one-hot grant), reserve_valid_i/reserve_addr_i
//   regfile side   : write_enable_o, write_addr_o, write_data_o
//   core side      : busy_o (pending-write scoreboard), r15_drop_o
// Modports:
//   slave  : the arbiter itself
//   master : whatever drives the requests and consumes the write port
// ---------------------------------------------------------------------------
interface regfile_write_arbiter_if
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = REG_DATA_W,
    parameter int ADDR_W  = REG_ADDR_W
) ();

    logic [NUM_REQ-1:0]        req_valid_i;
    logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
    logic [NUM_REQ*DATA_W-1:0] req_data_i;
    logic [NUM_REQ-1:0]        req_ready_o;

    logic                      reserve_valid_i;
    logic [ADDR_W-1:0]         reserve_addr_i;

    logic                      write_enable_o;
    logic [ADDR_W-1:0]         write_addr_o;
    logic [DATA_W-1:0]         write_data_o;

    logic [2**ADDR_W-2:0]      busy_o;
    logic                      r15_drop_o;

    modport slave (
        input  req_valid_i, req_addr_i, req_data_i,
        input  reserve_valid_i, reserve_addr_i,
        output req_ready_o,
        output write_enable_o, write_addr_o, write_data_o,
        output busy_o, r15_drop_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_data_i,
        output reserve_valid_i, reserve_addr_i,
        input  req_ready_o,
        input  write_enable_o, write_addr_o, write_data_o,
        input  busy_o, r15_drop_o
    );

endinterface : regfile_write_arbiter_if

// File: rtl/prio_arbiter.sv
// ---------------------------------------------------------------------------
// prio_arbiter
// Purely combinational two-level fixed-priority arbiter.
//   valid    in  N   requesters asking this cycle
//   promoted in  N   requesters that have waited long enough to jump the queue
//   grant    out N   one-hot (or zero) winner
// If any valid requester is promoted, the lowest-index promoted one wins;
// otherwise the lowest-index valid requester wins.
// ---------------------------------------------------------------------------
module prio_arbiter #(
    parameter int N = 3
) (
    input  logic [N-1:0] valid,
    input  logic [N-1:0] promoted,
    output logic [N-1:0] grant
);

    logic [N-1:0] promoted_valid;
    logic [N-1:0] sel;

    // A promoted bit is only meaningful for a requester that is still asking.
    assign promoted_valid = valid & promoted;
    assign sel            = (|promoted_valid) ? promoted_valid : valid;

    // Lowest set bit of sel: each bit wins only if every lower bit is clear.
    // Computed per bit (no ripple chain) so the tools see a flat AND tree.
    for (genvar gi = 0; gi < N; gi++) begin : g_pick
        if (gi == 0) begin : g_first
            assign grant[gi] = sel[gi];
        end else begin : g_rest
            assign grant[gi] = sel[gi] && (sel[gi-1:0] == '0);
        end
    end

endmodule : prio_arbiter

// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
// Shares the single regfile write port between NUM_REQ writeback sources
// (0 = pipeline writeback, 1 = load/multicycle unit, 2 = debug/init).
//   clk_i   in  clock, rising edge
//   rst_ni  in  asynchronous active-low reset
//   bus     slave modport of regfile_write_arbiter_if (requests, grant,
//           registered regfile write port, busy scoreboard, R15 drop pulse)
// Behaviour summary:
//   - Combinational grant each cycle, fixed priority with a starvation guard:
//     a valid requester left waiting MAX_WAIT cycles is promoted above others.
//   - The granted write is registered and presented to the regfile one cycle
//     later. Writes to R15 are accepted but dropped, with a one-cycle pulse.
//   - busy_o tracks registers reserved by long-latency ops; a granted write
//     clears its bit, a same-cycle reserve of the same register wins.
// ---------------------------------------------------------------------------
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int DATA_W   = REG_DATA_W,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int MAX_WAIT = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    regfile_write_arbiter_if.slave  bus
);

    localparam int                WAIT_W    = wait_cnt_w(MAX_WAIT);
    localparam int                NUM_REGS  = 2**ADDR_W - 1;
    localparam logic [ADDR_W-1:0] DROP_ADDR = '1;
    localparam logic [WAIT_W-1:0] WAIT_SAT  = WAIT_W'(MAX_WAIT);

    // -----------------------------------------------------------------------
    // Request unpacking and wait counters
    // -----------------------------------------------------------------------
    logic [ADDR_W-1:0]  req_addr [NUM_REQ];
    logic [DATA_W-1:0]  req_data [NUM_REQ];
    logic [NUM_REQ-1:0] promoted;
    logic [NUM_REQ-1:0] grant_raw;
    logic [NUM_REQ-1:0] grant;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        logic [WAIT_W-1:0] wait_reg;
        logic [WAIT_W-1:0] wait_next;

        assign req_addr[gi] = bus.req_addr_i[gi*ADDR_W +: ADDR_W];
        assign req_data[gi] = bus.req_data_i[gi*DATA_W +: DATA_W];
        assign promoted[gi] = (wait_reg == WAIT_SAT);

        // Count only while asking and losing; a grant or a withdrawn request
        // starts the wait over from zero.
        always_comb begin
            wait_next = '0;
            if (bus.req_valid_i[gi] && !grant[gi]) begin
                wait_next = (wait_reg == WAIT_SAT) ? wait_reg : wait_reg + 1'b1;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                wait_reg <= '0;
            end else begin
                wait_reg <= wait_next;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Arbitration
    // -----------------------------------------------------------------------
    prio_arbiter #(
        .N (NUM_REQ)
    ) u_prio_arbiter (
        .valid    (bus.req_valid_i),
        .promoted (promoted),
        .grant    (grant_raw)
    );

    // No grant may be seen while reset is held, even if requesters are valid.
    assign grant           = grant_raw & {NUM_REQ{rst_ni}};
    assign bus.req_ready_o = grant;

    // -----------------------------------------------------------------------
    // Winner select (grant is one-hot, so an OR of masked inputs is a mux)
    // -----------------------------------------------------------------------
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;
    logic              any_grant;
    logic              win_is_r15;

    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                win_addr = win_addr | req_addr[k];
                win_data = win_data | req_data[k];
            end
        end
    end

    assign any_grant  = |grant;
    assign win_is_r15 = (win_addr == DROP_ADDR);

    // -----------------------------------------------------------------------
    // Registered regfile write port
    // -----------------------------------------------------------------------
    logic              write_enable_reg;
    logic [ADDR_W-1:0] write_addr_reg;
    logic [DATA_W-1:0] write_data_reg;
    logic              r15_drop_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            write_enable_reg <= 1'b0;
            write_addr_reg   <= '0;
            write_data_reg   <= '0;
            r15_drop_reg     <= 1'b0;
        end else begin
            // R15 is accepted from the requester but never reaches the regfile.
            write_enable_reg <= any_grant && !win_is_r15;
            r15_drop_reg     <= any_grant &&  win_is_r15;
            if (any_grant) begin
                write_addr_reg <= win_addr;
                write_data_reg <= win_data;
            end
        end
    end

    assign bus.write_enable_o = write_enable_reg;
    assign bus.write_addr_o   = write_addr_reg;
    assign bus.write_data_o   = write_data_reg;
    assign bus.r15_drop_o     = r15_drop_reg;

    // -----------------------------------------------------------------------
    // Pending-write scoreboard
    // Only R0..R14 have a bit, so reserving or writing R15 never matches.
    // -----------------------------------------------------------------------
    logic [NUM_REGS-1:0] busy_reg;
    logic [NUM_REGS-1:0] busy_next;
    logic [NUM_REGS-1:0] busy_set;
    logic [NUM_REGS-1:0] busy_clr;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
        assign busy_set[gi] = bus.reserve_valid_i && (bus.reserve_addr_i == ADDR_W'(gi));
        assign busy_clr[gi] = any_grant && (win_addr == ADDR_W'(gi));
    end

    // Set is applied after clear: a reserve in the same cycle as a write to the
    // same register belongs to a newer outstanding op and must survive.
    assign busy_next = (busy_reg & ~busy_clr) | busy_set;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign bus.busy_o = busy_reg;

endmodule : regfile_write_arbiter
